// File: rtl/mem_cmd_ctrl.sv
// Request FIFO plus strobe sequencer for a small scratch memory; reads return on a one-cycle response pulse.
// Optional write-verify read-back is enabled by defining MEMCTL_WR_VERIFY_EN.
module mem_cmd_ctrl #(
    parameter int ADDR_W     = 2,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_wr,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    output logic                          rsp_valid,
    output logic [ADDR_W-1:0]             rsp_addr,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_wr_en,
    output logic                          mem_rd_en,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          verify_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

`ifdef MEMCTL_WR_VERIFY_EN
    typedef enum logic [2:0] {IDLE, XFER, RDWAIT, VRD, VWAIT} state_e;
`else
    typedef enum logic [2:0] {IDLE, XFER, RDWAIT} state_e;
`endif

    state_e             state_q;
    logic [ENT_W-1:0]   fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop, cur_wr_q;
    logic [ENT_W-1:0]   head;
    logic [ADDR_W-1:0]  mem_addr_q, rsp_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q, rsp_rdata_q;
    logic               mem_wr_en_q, mem_rd_en_q, rsp_valid_q;

    assign req_ready = (count_q != FULL_CNT);
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign head      = fifo_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Entry storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= {req_wr, req_addr, req_wdata};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef MEMCTL_WR_VERIFY_EN
    logic verify_err_q;
    assign verify_err = verify_err_q;
`else
    assign verify_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cur_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_rdata_q <= '0;
`ifdef MEMCTL_WR_VERIFY_EN
            verify_err_q <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        cur_wr_q    <= head[ENT_W-1];
                        mem_addr_q  <= head[DATA_W +: ADDR_W];
                        mem_wdata_q <= head[DATA_W-1:0];
                        mem_wr_en_q <= head[ENT_W-1];
                        mem_rd_en_q <= !head[ENT_W-1];
                        state_q     <= XFER;
                    end
                end
                XFER: begin
                    mem_wr_en_q <= 1'b0;
                    mem_rd_en_q <= 1'b0;
                    if (cur_wr_q) begin
`ifdef MEMCTL_WR_VERIFY_EN
                        // Read the just-written location back at the same address.
                        mem_rd_en_q <= 1'b1;
                        state_q     <= VRD;
`else
                        state_q     <= IDLE;
`endif
                    end else begin
                        state_q <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    rsp_valid_q <= 1'b1;
                    rsp_addr_q  <= mem_addr_q;
                    rsp_rdata_q <= mem_rdata;
                    state_q     <= IDLE;
                end
`ifdef MEMCTL_WR_VERIFY_EN
                VRD: begin
                    mem_rd_en_q <= 1'b0;
                    state_q     <= VWAIT;
                end
                VWAIT: begin
                    if (mem_rdata != mem_wdata_q) verify_err_q <= 1'b1;
                    state_q <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wr_en  = mem_wr_en_q;
    assign mem_rd_en  = mem_rd_en_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_addr   = rsp_addr_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign fifo_count = count_q;
endmodule

// File: tb/tb_mem_cmd_ctrl.sv
// Self-checking bench for mem_cmd_ctrl: directed vector table, corner sequences and a random
// stream checked against an in-order transaction model with a shadow copy of memory.
module tb_mem_cmd_ctrl;
    localparam int AW = 2, DW = 8, DEPTH = 4;

    logic clk = 1'b0, rst = 1'b0;
    logic req_valid = 1'b0, req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic req_ready, rsp_valid, mem_wr_en, mem_rd_en, verify_err;
    logic [AW-1:0] rsp_addr, mem_addr;
    logic [DW-1:0] rsp_rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [$clog2(DEPTH):0] fifo_count;

    always #5 clk = ~clk;

    mem_cmd_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_addr(rsp_addr),
        .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .fifo_count(fifo_count), .verify_err(verify_err)
    );

    // Scratch memory: one-cycle read latency, optional corruption of writes to address 1.
    logic [DW-1:0] mem_arr [4] = '{default: '0};
    bit corrupt_en = 1'b0;
    always @(posedge clk) begin
        if (mem_wr_en) mem_arr[mem_addr] <= (corrupt_en && mem_addr == 2'd1) ? ~mem_wdata : mem_wdata;
        if (mem_rd_en) mem_rdata <= mem_arr[mem_addr];
    end

    int n_checks = 0, n_fail = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: requests in acceptance order, shadow memory updated at acceptance.
    typedef struct packed {logic wr; logic vfy; logic [AW-1:0] a; logic [DW-1:0] d;} op_t;
    typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} rsp_t;
    op_t  exp_ops[$];
    rsp_t exp_rsp[$];
    int   due_q[$];
    logic [DW-1:0] shadow [4] = '{default: '0};
    int acc = 0, pops = 0, cyc = 0, max_cnt = 0, n_wrp = 0, n_rdp = 0, n_rsp = 0;
    bit mon_en = 1'b0, saw_full = 1'b0, prev_wr = 1'b0, prev_rd = 1'b0;
    logic [DW-1:0] last_rsp_d = '0;

    always @(posedge clk) cyc++;

    task automatic model_push(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (wr) begin
            shadow[a] = d;
            exp_ops.push_back('{wr: 1'b1, vfy: 1'b0, a: a, d: d});
        end else begin
            exp_ops.push_back('{wr: 1'b0, vfy: 1'b0, a: a, d: '0});
            exp_rsp.push_back('{a: a, d: shadow[a]});
        end
        acc++;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            op_t o;
            rsp_t r;
            check("strobe_exclusive", {31'd0, mem_wr_en & mem_rd_en}, 0);
            if (mem_wr_en || mem_rd_en) begin
                check("strobe_one_cycle", {31'd0, (mem_wr_en && prev_wr) || (mem_rd_en && prev_rd)}, 0);
                check("strobe_expected", {31'd0, exp_ops.size() > 0}, 1);
                if (exp_ops.size() > 0) begin
                    o = exp_ops.pop_front();
                    check("strobe_type", {31'd0, mem_wr_en}, {31'd0, o.wr});
                    check("mem_addr", mem_addr, o.a);
                    if (o.wr) begin
                        check("mem_wdata", mem_wdata, o.d);
                        n_wrp++;
                        pops++;
`ifdef MEMCTL_WR_VERIFY_EN
                        exp_ops.push_front('{wr: 1'b0, vfy: 1'b1, a: o.a, d: o.d});
`endif
                    end else if (!o.vfy) begin
                        due_q.push_back(cyc + 2);
                        n_rdp++;
                        pops++;
                    end
                end
            end
            prev_wr = mem_wr_en;
            prev_rd = mem_rd_en;
            if (rsp_valid) begin
                check("rsp_expected", {31'd0, exp_rsp.size() > 0 && due_q.size() > 0}, 1);
                if (exp_rsp.size() > 0 && due_q.size() > 0) begin
                    r = exp_rsp.pop_front();
                    check("rsp_latency", cyc, due_q.pop_front());
                    check("rsp_addr", rsp_addr, r.a);
                    check("rsp_rdata", rsp_rdata, r.d);
                    last_rsp_d = rsp_rdata;
                    n_rsp++;
                end
            end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
                check("rsp_on_time", {31'd0, rsp_valid}, 1);
                void'(due_q.pop_front());
                if (exp_rsp.size() > 0) void'(exp_rsp.pop_front());
            end
            check("fifo_count", fifo_count, acc - pops);
            check("req_ready", {31'd0, req_ready}, {31'd0, (acc - pops) != DEPTH});
            if (fifo_count == DEPTH) saw_full = 1'b1;
            if (int'(fifo_count) > max_cnt) max_cnt = fifo_count;
        end
    end

    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, output int waited);
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
        waited = 0;
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("accept_in_time", {31'd0, waited < 200}, 1);
        @(posedge clk);
        if (waited < 200) model_push(wr, a, d);
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while ((exp_ops.size() != 0 || due_q.size() != 0 || acc != pops) && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check("drain_in_time", {31'd0, t < 100}, 1);
    endtask

    task automatic clear_model();
        exp_ops.delete(); exp_rsp.delete(); due_q.delete();
        acc = 0; pops = 0; prev_wr = 1'b0; prev_rd = 1'b0;
    endtask

    typedef struct {logic wr; logic [AW-1:0] a; logic [DW-1:0] d; logic [DW-1:0] exp_rd;} vec_t;
    vec_t vt[8];

    initial begin
        int w, w0, r0, s0, seen;
        vt[0] = '{1'b1, 2'd2, 8'hA5, 8'h00};
        vt[1] = '{1'b0, 2'd2, 8'h00, 8'hA5};
        vt[2] = '{1'b1, 2'd0, 8'h00, 8'h00};
        vt[3] = '{1'b1, 2'd3, 8'hFF, 8'h00};
        vt[4] = '{1'b0, 2'd0, 8'h00, 8'h00};
        vt[5] = '{1'b0, 2'd3, 8'h00, 8'hFF};
        vt[6] = '{1'b1, 2'd2, 8'h5A, 8'h00};
        vt[7] = '{1'b0, 2'd2, 8'h00, 8'h5A};

        // Reset values with rst held low for three cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        check("rst_rsp_addr", rsp_addr, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wr_en", {31'd0, mem_wr_en}, 0);
        check("rst_mem_rd_en", {31'd0, mem_rd_en}, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_verify_err", {31'd0, verify_err}, 0);
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_no_strobes", n_wrp + n_rdp, 0);

        // Directed single transactions, each drained before the next.
        for (int i = 0; i < 8; i++) begin
            w0 = n_wrp; r0 = n_rdp; s0 = n_rsp;
            send(vt[i].wr, vt[i].a, vt[i].d, w);
            drain();
            check("vec_wr_pulses", n_wrp - w0, {31'd0, vt[i].wr});
            check("vec_rd_pulses", n_rdp - r0, {31'd0, !vt[i].wr});
            check("vec_rsp_pulses", n_rsp - s0, {31'd0, !vt[i].wr});
            if (!vt[i].wr) check("vec_rdata", last_rsp_d, vt[i].exp_rd);
        end

        // Back-to-back reads until the FIFO fills; the seventh must wait two cycles.
        saw_full = 1'b0; s0 = n_rsp; seen = 0;
        for (int i = 0; i < 6; i++) begin
            send(1'b0, AW'(i), 8'h00, w);
            seen += w;
        end
        send(1'b0, 2'd2, 8'h00, w);
        check("full_first6_no_wait", seen, 0);
        check("full_7th_wait", w, 2);
        drain();
        check("full_seen", {31'd0, saw_full}, 1);
        check("full_rsp_count", n_rsp - s0, 7);

        // Twelve streamed writes: pointer wrap and push/pop on the same edge.
        saw_full = 1'b0; max_cnt = 0; w0 = n_wrp;
        for (int i = 0; i < 12; i++) send(1'b1, AW'(i % 4), DW'($urandom_range(0, 255)), w);
        drain();
        check("wrap_wr_pulses", n_wrp - w0, 12);
        check("wrap_max_count", max_cnt, DEPTH);
        for (int i = 0; i < 4; i++) send(1'b0, AW'(i), 8'h00, w);
        drain();

        // Random stream against the model.
        for (int i = 0; i < 150; i++) begin
            send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), DW'($urandom_range(0, 255)), w);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                req_valid = 1'b0;
            end
        end
        drain();

        // Asynchronous reset while a read waits for data with two requests queued.
        for (int i = 0; i < 3; i++) send(1'b0, AW'(i), 8'h00, w);
        @(negedge clk);
        req_valid = 1'b0;
        check("midrst_queued", fifo_count, 2);
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_rd_en", {31'd0, mem_rd_en}, 0);
        check("midrst_count", fifo_count, 0);
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 0);
        clear_model();
        seen = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen += int'(rsp_valid) + int'(mem_rd_en) + int'(mem_wr_en);
        end
        check("midrst_quiet_after", seen, 0);
        check("midrst_count_after", fifo_count, 0);
        mon_en = 1'b1;

`ifdef MEMCTL_WR_VERIFY_EN
        corrupt_en = 1'b1;
        send(1'b1, 2'd0, 8'h11, w);
        drain();
        check("verify_clean_write", {31'd0, verify_err}, 0);
        s0 = n_rsp;
        send(1'b1, 2'd1, 8'h3C, w);
        drain();
        check("verify_err_set", {31'd0, verify_err}, 1);
        check("verify_no_rsp", n_rsp - s0, 0);
        send(1'b1, 2'd0, 8'h22, w);
        drain();
        check("verify_err_sticky", {31'd0, verify_err}, 1);
`else
        send(1'b1, 2'd1, 8'h3C, w);
        drain();
        check("verify_err_tied", {31'd0, verify_err}, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
